// File: rtl/collatz_pkg.sv
// collatz_pkg: shared FSM state encoding and count width for the Collatz range engine
package collatz_pkg;
    localparam int CNT_W = 16;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, STORE, DONE} state_t;
endpackage

// File: rtl/collatz_step.sv
// collatz_step: per-number Collatz engine; load_i/value_i seed it, busy_o stays high while more steps follow, count_o is the running count
module collatz_step
    import collatz_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [31:0]      value_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o
);
    logic [31:0]      v_q;
    logic [31:0]      nv;
    logic [CNT_W-1:0] c_q;
    assign nv = v_q[0] ? {v_q[30:0], 1'b0} + v_q + 32'd1 : v_q >> 1;
    // busy_o looks one step ahead so the sequencer leaves ITER on the cycle the final step lands
    assign busy_o  = load_i ? value_i > 32'd1 : (v_q > 32'd1 && nv > 32'd1);
    assign count_o = c_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
        end else if (load_i) begin
            v_q <= value_i;
            c_q <= {{(CNT_W-1){1'b0}}, value_i != 32'd0};
        end else if (v_q > 32'd1) begin
            v_q <= nv;
            c_q <= (&c_q) ? c_q : c_q + 1'b1;
        end
    end
endmodule

// File: rtl/collatz_range.sv
// collatz_range: runs Collatz counts for RAM_WORDS consecutive start values into a result RAM
// ports: go starts a run at n0=start; start[RAM_ADDR_BITS-1:0] is the read address otherwise;
// done is a held completion level; count is the registered RAM read (1-cycle latency)
module collatz_range
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [31:0]      start,
    output logic             done,
    output logic [CNT_W-1:0] count
);
    state_t                   state_q;
    logic [31:0]              base_q;
    logic [RAM_ADDR_BITS-1:0] i_q;
    logic                     done_q;
    logic [CNT_W-1:0]         count_q;
    logic                     busy;
    logic [CNT_W-1:0]         c;
    logic [CNT_W-1:0]         ram [RAM_WORDS];
    logic                     load;
    logic [31:0]              value;
    assign load  = state_q == LOAD;
    assign value = base_q + 32'(i_q);
    assign done  = done_q;
    assign count = count_q;
    collatz_step u_step (
        .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .busy_o(busy), .count_o(c)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (go) begin
                    base_q  <= start;
                    i_q     <= '0;
                    done_q  <= 1'b0;
                    state_q <= LOAD;
                end
                // values 0 and 1 need no steps and go straight to STORE
                LOAD: state_q <= busy ? ITER : STORE;
                ITER: if (!busy) state_q <= STORE;
                STORE: if (i_q == RAM_ADDR_BITS'(RAM_WORDS - 1)) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    i_q     <= i_q + 1'b1;
                    state_q <= LOAD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == STORE) ram[i_q] <= c;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else count_q <= ram[start[RAM_ADDR_BITS-1:0]];
    end
endmodule
